// File: rtl/tone_pkg.sv
// Shared types and constants for the tone arbiter slice.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CLK_HZ           = 50_000_000;
    localparam int TICKS_PER_MS_DEF = CLK_HZ / 1000;
    localparam int FREQ_W           = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request searching upward from the pointer,
// which then advances past the winner.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           winner,
    output logic [$clog2(NREQ)-1:0]   win_idx,
    output logic                      valid
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && enable && req[idx]) begin
                valid       = 1'b1;
                win_idx     = PW'(idx);
                winner[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        if (win_idx == PW'(NREQ - 1)) ptr_next = '0;
        else                          ptr_next = win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     ptr_reg <= '0;
        else if (valid) ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/tone_arbiter.sv
// Shares one square-wave tone generator among NREQ requesters: round-robin
// grant, play for the latched duration, then a fixed silent gap.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
    parameter int GAP_MS       = 10,
    parameter int DUR_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [FREQ_W*NREQ-1:0]  freq,
    input  logic [DUR_W*NREQ-1:0]   dur_ms,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [FREQ_W-1:0]       tone_f,
    output logic                    tone_rst,
    output logic                    busy
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_MS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    logic [FREQ_W-1:0] freq_arr [NREQ];
    logic [DUR_W-1:0]  dur_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign freq_arr[gi] = freq[FREQ_W*gi +: FREQ_W];
            assign dur_arr[gi]  = dur_ms[DUR_W*gi +: DUR_W];
        end
    endgenerate

    state_t            state_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [NREQ-1:0]   ack_reg;
    logic [FREQ_W-1:0] tone_f_reg;
    logic              tone_rst_reg;
    logic              busy_reg;
    logic [PW-1:0]     win_reg;
    logic [NREQ-1:0]   win_onehot_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic [TW-1:0]     tick_reg;
    logic [DUR_W-1:0]  ms_reg;

    logic [NREQ-1:0] arb_winner;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_reg == IDLE),
        .req     (req),
        .winner  (arb_winner),
        .win_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Nested prescaler/ms counters replace a dur*TICKS multiply.
    logic tick_last, play_last, gap_last;
    assign tick_last = (tick_reg == TICK_LAST);
    assign play_last = tick_last && (ms_reg == dur_reg - 1'b1);
    assign gap_last  = (GAP_MS == 0) || (tick_last && (ms_reg == GAP_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            ack_reg        <= '0;
            tone_f_reg     <= '0;
            tone_rst_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            win_reg        <= '0;
            win_onehot_reg <= '0;
            dur_reg        <= '0;
            tick_reg       <= '0;
            ms_reg         <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        win_reg        <= arb_idx;
                        win_onehot_reg <= arb_winner;
                        dur_reg        <= dur_arr[arb_idx];
                        tick_reg       <= '0;
                        ms_reg         <= '0;
                        busy_reg       <= 1'b1;
                        if (dur_arr[arb_idx] == '0) begin
                            state_reg <= GAP;
                            ack_reg   <= arb_winner;
                        end else begin
                            state_reg    <= PLAY;
                            gnt_reg      <= arb_winner;
                            tone_f_reg   <= freq_arr[arb_idx];
                            // A zero frequency is a rest: keep the generator held in reset.
                            tone_rst_reg <= (freq_arr[arb_idx] == '0);
                        end
                    end
                end
                PLAY: begin
                    if (!req[win_reg] || play_last) begin
                        state_reg    <= GAP;
                        gnt_reg      <= '0;
                        tone_f_reg   <= '0;
                        tone_rst_reg <= 1'b1;
                        tick_reg     <= '0;
                        ms_reg       <= '0;
                        if (req[win_reg]) ack_reg <= win_onehot_reg;
                    end else if (tick_last) begin
                        tick_reg <= '0;
                        ms_reg   <= ms_reg + 1'b1;
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        tick_reg  <= '0;
                        ms_reg    <= '0;
                    end else if (tick_last) begin
                        tick_reg <= '0;
                        ms_reg   <= ms_reg + 1'b1;
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign ack      = ack_reg;
    assign tone_f   = tone_f_reg;
    assign tone_rst = tone_rst_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with TICKS_PER_MS=4, GAP_MS=1, NREQ=4.
module tb_tone_arbiter;

    localparam int NREQ  = 4;
    localparam int DUR_W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  freq;
    logic [DUR_W*NREQ-1:0] dur_ms;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [31:0]         tone_f;
    logic                tone_rst;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int ack_count = 0;

    tone_arbiter #(
        .NREQ(NREQ), .TICKS_PER_MS(4), .GAP_MS(1), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .freq(freq), .dur_ms(dur_ms),
        .gnt(gnt), .ack(ack), .tone_f(tone_f), .tone_rst(tone_rst), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) ack_count <= ack_count + $countones(ack);

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_note(input int i, input int f, input int d);
        freq[32*i +: 32]       = f;
        dur_ms[DUR_W*i +: DUR_W] = DUR_W'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check_val("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == '0 && n < 200) begin tick(); n++; end
        check_val("gnt_seen", {31'd0, gnt != '0}, 32'd1);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack == '0 && n < 200) begin tick(); n++; end
        check_val("ack_seen", {31'd0, ack != '0}, 32'd1);
    endtask

    initial begin
        int acks0;
        rst_n  = 1'b0;
        req    = '0;
        freq   = '0;
        dur_ms = '0;
        for (int i = 0; i < NREQ; i++) set_note(i, 100 * (i + 1), 1);

        // Reset held with all requests asserted
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("rst_gnt", gnt, 0);
            check_val("rst_ack", ack, 0);
            check_val("rst_tone_f", tone_f, 0);
            check_val("rst_tone_rst", tone_rst, 1);
            check_val("rst_busy", busy, 0);
        end
        rst_n = 1'b1;
        tick();
        check_val("first_gnt", gnt, 4'b0001);
        check_val("first_tone_f", tone_f, 100);
        req = '0;
        wait_idle();

        // Single note: 440 Hz for 2 ms
        set_note(0, 440, 2);
        req = 4'b0001;
        tick();
        for (int k = 1; k <= 8; k++) begin
            check_val($sformatf("single_gnt_%0d", k), gnt, 4'b0001);
            check_val($sformatf("single_f_%0d", k), tone_f, 440);
            check_val($sformatf("single_rst_%0d", k), tone_rst, 0);
            check_val($sformatf("single_ack_%0d", k), ack, 0);
            tick();
        end
        check_val("single_ack", ack, 4'b0001);
        check_val("single_end_rst", tone_rst, 1);
        check_val("single_end_gnt", gnt, 0);
        check_val("single_end_f", tone_f, 0);
        req = '0;
        for (int k = 10; k <= 12; k++) begin
            tick();
            check_val($sformatf("single_gap_busy_%0d", k), busy, 1);
            check_val($sformatf("single_gap_ack_%0d", k), ack, 0);
        end
        tick();
        check_val("single_idle_busy", busy, 0);

        // Fairness, releasing each requester on its ack
        for (int i = 0; i < NREQ; i++) set_note(i, 100 * (i + 1), 1);
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            wait_gnt();
            check_val($sformatf("fairA_gnt_%0d", i), gnt, 32'(1 << i));
            wait_ack();
            check_val($sformatf("fairA_ack_%0d", i), ack, 32'(1 << i));
            req[i] = 1'b0;
        end
        wait_idle();

        // Fairness, all held continuously
        do_reset();
        acks0 = ack_count;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt();
            check_val($sformatf("fairB_gnt_%0d", i), gnt, 32'(1 << (i % 4)));
            wait_ack();
            check_val($sformatf("fairB_ack_%0d", i), ack, 32'(1 << (i % 4)));
        end
        req = '0;
        wait_idle();
        check_val("fairB_ack_count", ack_count - acks0, 5);

        // Zero-duration note
        do_reset();
        set_note(0, 440, 0);
        req = 4'b0001;
        tick();
        check_val("zero_ack", ack, 4'b0001);
        check_val("zero_gnt", gnt, 0);
        check_val("zero_rst", tone_rst, 1);
        check_val("zero_busy", busy, 1);
        req = '0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_val($sformatf("zero_gap_gnt_%0d", k), gnt, 0);
            check_val($sformatf("zero_gap_rst_%0d", k), tone_rst, 1);
        end
        tick();
        check_val("zero_idle", busy, 0);

        // Rest note: frequency 0
        set_note(1, 0, 1);
        req = 4'b0010;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check_val($sformatf("rest_gnt_%0d", k), gnt, 4'b0010);
            check_val($sformatf("rest_rst_%0d", k), tone_rst, 1);
            tick();
        end
        check_val("rest_ack", ack, 4'b0010);
        req = '0;
        wait_idle();

        // Abort: requester 1 drops its request mid-note
        do_reset();
        set_note(1, 200, 3);
        set_note(2, 300, 1);
        acks0 = ack_count;
        req = 4'b0110;
        tick();
        check_val("abort_gnt1", gnt, 4'b0010);
        tick();
        req[1] = 1'b0;
        tick();
        check_val("abort_gnt", gnt, 0);
        check_val("abort_rst", tone_rst, 1);
        check_val("abort_ack", ack, 0);
        check_val("abort_state", 32'(dut.state_reg), 32'(tone_pkg::GAP));
        wait_gnt();
        check_val("abort_next_gnt", gnt, 4'b0100);
        check_val("abort_no_ack1", ack_count - acks0, 0);
        wait_ack();
        check_val("abort_ack2", ack, 4'b0100);
        req = '0;
        wait_idle();

        // Reset in the middle of a note
        set_note(1, 200, 5);
        set_note(3, 400, 5);
        req = 4'b1010;
        tick();
        check_val("midrst_gnt3", gnt, 4'b1000);
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midrst_gnt", gnt, 0);
        check_val("midrst_ack", ack, 0);
        check_val("midrst_f", tone_f, 0);
        check_val("midrst_rst", tone_rst, 1);
        check_val("midrst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check_val("midrst_next_gnt", gnt, 4'b0010);
        req = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares one square-wave tone generator between NREQ requesters on the 50 MHz clock. Each requester asks for one note: a frequency in Hz and a duration in ms.
- Requesters are arbitrated round-robin. The winner's note is latched, the generator is driven for the note duration, and then a fixed silent gap is inserted before the next grant.
- Outputs tone_f and tone_rst connect directly to the generator's f and rst inputs. The generator is active-high reset.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TICKS_PER_MS, 50000, clock cycles per millisecond; benches override this with a small value
- GAP_MS, 10, silent gap after each note, in ms
- DUR_W, 16, width of each duration field

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active-low
- req  in  NREQ  request level per requester; must be held until ack
- freq  in  32*NREQ  note frequency in Hz; requester i uses bits [32i+31:32i]
- dur_ms  in  DUR_W*NREQ  note duration in ms; requester i uses bits [DUR_W*i+DUR_W-1:DUR_W*i]
- gnt  out  NREQ  one-hot grant, high while that requester's note plays
- ack  out  NREQ  one-cycle pulse when a note completes
- tone_f  out  32  frequency to the generator
- tone_rst  out  1  generator reset; high means silent
- busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, PLAY, GAP. All outputs are registered.
- Reset (rst_n low at a clock edge), applied from any state, mid-note included:
  - state goes to IDLE; gnt=0, ack=0, tone_f=0, tone_rst=1, busy=0
  - round-robin pointer set so requester 0 has top priority
  - all counters cleared
- IDLE, with any req bit high at cycle N:
  - the winner is the first set bit searching upward from (last winner + 1) mod NREQ
  - freq and dur_ms of the winner are latched; later input changes are ignored
  - the pointer advances past the winner
- IDLE, normal grant (dur_ms != 0). From cycle N+1:
  - state is PLAY, gnt[w]=1, tone_f = latched freq
  - tone_rst = 0, except tone_rst = 1 if latched freq == 0 (rest note; avoids the generator's divide-by-zero)
- IDLE, zero duration (dur_ms == 0):
  - no PLAY; at N+1 the state is GAP
  - ack[w] pulses at N+1, gnt stays 0, tone_rst stays 1
- PLAY:
  - lasts exactly dur_ms × TICKS_PER_MS cycles, counted with a tick prescaler (width clog2(TICKS_PER_MS)) and an ms counter (DUR_W bits)
  - on the cycle after the last PLAY cycle: state is GAP, ack[w] pulses for 1 cycle, gnt=0, tone_rst=1, tone_f=0
- Abort: if req[w] drops during PLAY, the next cycle is GAP with no ack, gnt=0, tone_rst=1.
- GAP:
  - lasts GAP_MS × TICKS_PER_MS cycles; GAP_MS == 0 gives a single cycle
  - then IDLE; requests are sampled in the first IDLE cycle
- Other rules:
  - ack and gnt are never both high for the same requester in the same cycle
  - at most one gnt bit is high
  - req changes by non-granted requesters during PLAY or GAP have no effect until IDLE
- Arithmetic: counters compare against latched values. No multiply in hardware; the cycle count comes from nested prescaler and ms counters. Maximum note length is (2^DUR_W − 1) ms.

Decomposition:
- Package tone_pkg:
  - state enum (IDLE, PLAY, GAP)
  - CLK_HZ = 50_000_000
  - default TICKS_PER_MS
  - frequency width 32
- Sub-module rr_arbiter (NREQ parameter):
  - inputs: req, pointer, enable
  - outputs: one-hot winner, any-valid
  - purely combinational plus the pointer register
- The tone generator itself is instantiated at the top level, not inside this block.

Test Plan (TICKS_PER_MS=4, GAP_MS=1, NREQ=4, DUR_W=16):
- Reset: rst_n low 3 cycles with req=4'b1111 -> gnt=0, ack=0, tone_f=0, tone_rst=1, busy=0 throughout; after release, the first grant goes to requester 0.
- Single note: req[0]=1 at cycle N, freq0=440, dur0=2 -> gnt[0]=1, tone_f=440, tone_rst=0 for cycles N+1..N+8. At N+9: ack[0] pulse, tone_rst=1. GAP covers N+9..N+12; busy=0 at N+13.
- Fairness: all four req held, each dur=1, releasing req[i] on its ack -> grant order 0,1,2,3. With all four held continuously instead -> order 0,1,2,3,0; exactly one ack per note.
- Edge notes:
  - dur0=0 -> ack[0] at N+1, gnt never high, tone_rst never low.
  - freq1=0, dur1=1 -> gnt[1] high 4 cycles, tone_rst=1 throughout, ack[1] delivered.
- Abort: req[1] dropped 2 cycles into PLAY -> next cycle gnt=0, tone_rst=1, state GAP; no ack[1]; requester 2 granted after the gap.
- Reset mid-PLAY: rst_n low for 1 cycle -> reset values the next cycle; the next grant goes to the lowest pending requester from 0.
